// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: FSM state encodings,
// opcode constants and the bit positions of the instruction-register fields.
package control_sequencer_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T0   = 3'd1;
    localparam logic [2:0] ST_T1   = 3'd2;
    localparam logic [2:0] ST_T2   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;
    localparam logic [2:0] ST_T4   = 3'd5;
    localparam logic [2:0] ST_T5   = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    // Register-register ALU opcodes occupy a contiguous range
    localparam logic [4:0] OP_ALU_FIRST = 5'b00000;
    localparam logic [4:0] OP_ALU_LAST  = 5'b01100;
    localparam logic [4:0] OP_HALT      = 5'b11111;

    // Instruction register field positions
    localparam int IR_OPCODE_MSB = 31;
    localparam int IR_OPCODE_LSB = 27;
    localparam int IR_RA_MSB     = 26;
    localparam int IR_RA_LSB     = 23;
    localparam int IR_RB_MSB     = 22;
    localparam int IR_RB_LSB     = 19;
    localparam int IR_RC_MSB     = 18;
    localparam int IR_RC_LSB     = 15;

    // True when the opcode is one of the supported register-register ALU ops
    function automatic logic is_alu_op(input logic [4:0] opcode);
        return (opcode >= OP_ALU_FIRST) && (opcode <= OP_ALU_LAST);
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// 4-to-16 one-hot decoder used for general-register bus selects and
// write enables.
// Ports:
//   idx    - register index R0..R15
//   en     - when low the output is all zeros
//   onehot - one-hot select, bit idx set when en is high
module reg_select_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    // One-hot decode of the register index, gated by the enable
    always_comb begin
        onehot = 16'h0000;
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = 16'h0000;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a simple bus-based CPU. Steps through a
// fetch (T0-T2) and execute (T3-T5) sequence for register-register ALU
// instructions, halts on the HALT opcode and flags unsupported opcodes.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   run                 - level request to keep fetching instructions
//   IR_Data             - instruction register contents
//   *_select            - bus encoder selects
//   *_enable, read      - register enables and memory-read mux select
//   reg_select_out      - one-hot general-register bus select
//   reg_enable          - one-hot general-register write enable
//   alu_instruction     - ALU opcode, driven only in T4
//   done, illegal_op    - single-cycle status pulses
//   halted              - high while in HALT
//   instr_count         - completed instruction count (wraps)
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR_Data,
    output logic        PC_select,
    output logic        Z_HI_select,
    output logic        Z_LO_select,
    output logic        MDR_select,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        read,
    output logic [15:0] reg_select_out,
    output logic [15:0] reg_enable,
    output logic [4:0]  alu_instruction,
    output logic        done,
    output logic        illegal_op,
    output logic        halted,
    output logic [15:0] instr_count
);

    logic [2:0]  state_r;
    logic [2:0]  state_next_s;
    logic [15:0] instr_count_r;

    logic [4:0]  opcode_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [3:0]  rc_s;
    logic        op_alu_s;
    logic        op_halt_s;

    logic [3:0]  sel_idx_s;
    logic        sel_en_s;
    logic        wr_en_s;
    logic        ir_unused_s;

    assign opcode_s  = IR_Data[IR_OPCODE_MSB:IR_OPCODE_LSB];
    assign ra_s      = IR_Data[IR_RA_MSB:IR_RA_LSB];
    assign rb_s      = IR_Data[IR_RB_MSB:IR_RB_LSB];
    assign rc_s      = IR_Data[IR_RC_MSB:IR_RC_LSB];
    assign op_alu_s  = is_alu_op(opcode_s);
    assign op_halt_s = (opcode_s == OP_HALT);

    // Low IR bits carry no information for register-register instructions
    assign ir_unused_s = ^IR_Data[14:0];

    assign instr_count = instr_count_r;

    // Next-state selection
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_next_s = ST_T0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_T0: state_next_s = ST_T1;
            ST_T1: state_next_s = ST_T2;
            ST_T2: state_next_s = ST_T3;
            ST_T3: begin
                if (op_alu_s) begin
                    state_next_s = ST_T4;
                end else if (op_halt_s) begin
                    state_next_s = ST_HALT;
                end else if (run) begin
                    state_next_s = ST_T0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_T4: state_next_s = ST_T5;
            ST_T5: begin
                if (run) begin
                    state_next_s = ST_T0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and completed-instruction counter. The count is bumped
    // on the T4->T5 edge so it already reflects the instruction while done
    // is high in T5.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            instr_count_r <= 16'h0000;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_T4) begin
                instr_count_r <= instr_count_r + 16'h0001;
            end else begin
                instr_count_r <= instr_count_r;
            end
        end
    end

    // Moore output decode from the state register
    always_comb begin
        PC_select           = 1'b0;
        Z_HI_select         = 1'b0;
        Z_LO_select         = 1'b0;
        MDR_select          = 1'b0;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        read                = 1'b0;
        alu_instruction     = 5'b00000;
        done                = 1'b0;
        illegal_op          = 1'b0;
        halted              = 1'b0;
        sel_idx_s           = 4'd0;
        sel_en_s            = 1'b0;
        wr_en_s             = 1'b0;
        case (state_r)
            ST_T0: begin
                PC_select           = 1'b1;
                MAR_enable          = 1'b1;
                PC_increment_enable = 1'b1;
                Z_enable            = 1'b1;
            end
            ST_T1: begin
                Z_LO_select = 1'b1;
                PC_enable   = 1'b1;
                read        = 1'b1;
                MDR_enable  = 1'b1;
            end
            ST_T2: begin
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
            end
            ST_T3: begin
                // Only a supported op loads Y; HALT is silent, others flag
                if (op_alu_s) begin
                    Y_enable  = 1'b1;
                    sel_idx_s = rb_s;
                    sel_en_s  = 1'b1;
                end else if (op_halt_s) begin
                    Y_enable  = 1'b0;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            ST_T4: begin
                Z_enable        = 1'b1;
                sel_idx_s       = rc_s;
                sel_en_s        = 1'b1;
                alu_instruction = opcode_s;
            end
            ST_T5: begin
                Z_LO_select = 1'b1;
                wr_en_s     = 1'b1;
                done        = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    reg_select_decoder u_bus_select (
        .idx    (sel_idx_s),
        .en     (sel_en_s),
        .onehot (reg_select_out)
    );

    reg_select_decoder u_write_enable (
        .idx    (ra_s),
        .en     (wr_en_s),
        .onehot (reg_enable)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] IR_Data;
    logic        PC_select, Z_HI_select, Z_LO_select, MDR_select;
    logic        PC_enable, PC_increment_enable, IR_enable, Y_enable;
    logic        Z_enable, MAR_enable, MDR_enable, read;
    logic [15:0] reg_select_out;
    logic [15:0] reg_enable;
    logic [4:0]  alu_instruction;
    logic        done, illegal_op, halted;
    logic [15:0] instr_count;

    int errors = 0;
    int checks = 0;

    // Single-bit controls gathered into one vector, MSB first
    localparam logic [14:0] C_PCSEL  = 15'h4000;
    localparam logic [14:0] C_ZHI    = 15'h2000;
    localparam logic [14:0] C_ZLO    = 15'h1000;
    localparam logic [14:0] C_MDRSEL = 15'h0800;
    localparam logic [14:0] C_PCE    = 15'h0400;
    localparam logic [14:0] C_PCINC  = 15'h0200;
    localparam logic [14:0] C_IRE    = 15'h0100;
    localparam logic [14:0] C_YE     = 15'h0080;
    localparam logic [14:0] C_ZE     = 15'h0040;
    localparam logic [14:0] C_MARE   = 15'h0020;
    localparam logic [14:0] C_MDRE   = 15'h0010;
    localparam logic [14:0] C_RD     = 15'h0008;
    localparam logic [14:0] C_DONE   = 15'h0004;
    localparam logic [14:0] C_ILL    = 15'h0002;
    localparam logic [14:0] C_HALT   = 15'h0001;

    localparam logic [14:0] X_NONE = 15'h0000;
    localparam logic [14:0] X_T0   = C_PCSEL | C_MARE | C_PCINC | C_ZE;
    localparam logic [14:0] X_T1   = C_ZLO | C_PCE | C_RD | C_MDRE;
    localparam logic [14:0] X_T2   = C_MDRSEL | C_IRE;
    localparam logic [14:0] X_T3   = C_YE;
    localparam logic [14:0] X_T4   = C_ZE;
    localparam logic [14:0] X_T5   = C_ZLO | C_DONE;

    logic [14:0] ctl;
    assign ctl = {PC_select, Z_HI_select, Z_LO_select, MDR_select, PC_enable,
                  PC_increment_enable, IR_enable, Y_enable, Z_enable,
                  MAR_enable, MDR_enable, read, done, illegal_op, halted};

    control_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .run                 (run),
        .IR_Data             (IR_Data),
        .PC_select           (PC_select),
        .Z_HI_select         (Z_HI_select),
        .Z_LO_select         (Z_LO_select),
        .MDR_select          (MDR_select),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .read                (read),
        .reg_select_out      (reg_select_out),
        .reg_enable          (reg_enable),
        .alu_instruction     (alu_instruction),
        .done                (done),
        .illegal_op          (illegal_op),
        .halted              (halted),
        .instr_count         (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample on the following falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_state(input string tag, input logic [14:0] c_exp,
                               input logic [15:0] sel_exp, input logic [15:0] en_exp,
                               input logic [4:0] alu_exp);
        check({tag, ".ctl"}, {17'd0, ctl}, {17'd0, c_exp});
        check({tag, ".sel"}, {16'd0, reg_select_out}, {16'd0, sel_exp});
        check({tag, ".wen"}, {16'd0, reg_enable}, {16'd0, en_exp});
        check({tag, ".alu"}, {27'd0, alu_instruction}, {27'd0, alu_exp});
    endtask

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        IR_Data = 32'h0000_0000;
        step(2);
        check_state("reset", X_NONE, 16'h0000, 16'h0000, 5'b00000);
        check("reset.count", {16'd0, instr_count}, 32'd0);

        // First instruction: opcode 01010, Ra=1, Rb=3, Rc=5
        reset   = 1'b0;
        run     = 1'b1;
        IR_Data = 32'h509A_8000;
        step(1); check_state("i1.t0", X_T0, 16'h0000, 16'h0000, 5'b00000);
        step(1); check_state("i1.t1", X_T1, 16'h0000, 16'h0000, 5'b00000);
        step(1); check_state("i1.t2", X_T2, 16'h0000, 16'h0000, 5'b00000);
        step(1); check_state("i1.t3", X_T3, 16'h0008, 16'h0000, 5'b00000);
        step(1); check_state("i1.t4", X_T4, 16'h0020, 16'h0000, 5'b01010);
        check("i1.t4.count", {16'd0, instr_count}, 32'd0);
        step(1); check_state("i1.t5", X_T5, 16'h0000, 16'h0002, 5'b00000);
        check("i1.t5.count", {16'd0, instr_count}, 32'd1);

        // Back-to-back instructions, no IDLE gap
        step(1); check_state("i2.t0", X_T0, 16'h0000, 16'h0000, 5'b00000);
        step(5); check("i2.count", {16'd0, instr_count}, 32'd2);
        step(1); check_state("i3.t0", X_T0, 16'h0000, 16'h0000, 5'b00000);
        step(5); check("i3.count18", {16'd0, instr_count}, 32'd3);
        check_state("i3.t5", X_T5, 16'h0000, 16'h0002, 5'b00000);
        run = 1'b0;
        step(1); check_state("idle", X_NONE, 16'h0000, 16'h0000, 5'b00000);

        // Unsupported opcode 10101
        run     = 1'b1;
        IR_Data = 32'hA800_0000;
        step(4); check_state("ill.t3", C_ILL, 16'h0000, 16'h0000, 5'b00000);
        step(1); check_state("ill.next", X_T0, 16'h0000, 16'h0000, 5'b00000);
        check("ill.count", {16'd0, instr_count}, 32'd3);

        // Reset during T4 of a normal instruction, run still high
        IR_Data = 32'h509A_8000;
        step(4); check_state("rst4.t4", X_T4, 16'h0020, 16'h0000, 5'b01010);
        reset = 1'b1;
        step(1); check_state("rst4.idle", X_NONE, 16'h0000, 16'h0000, 5'b00000);
        check("rst4.count", {16'd0, instr_count}, 32'd0);
        reset = 1'b0;

        // HALT opcode
        IR_Data = 32'hF800_0000;
        step(4); check_state("halt.t3", X_NONE, 16'h0000, 16'h0000, 5'b00000);
        step(1); check_state("halt.enter", C_HALT, 16'h0000, 16'h0000, 5'b00000);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("halt.hold", {17'd0, ctl}, {17'd0, C_HALT});
        end
        reset = 1'b1;
        step(1); check_state("halt.reset", X_NONE, 16'h0000, 16'h0000, 5'b00000);
        reset = 1'b0;

        // run dropped in T2: instruction finishes, then IDLE
        IR_Data = 32'h509A_8000;
        step(3); check_state("drop.t2", X_T2, 16'h0000, 16'h0000, 5'b00000);
        run = 1'b0;
        step(3); check_state("drop.t5", X_T5, 16'h0000, 16'h0002, 5'b00000);
        check("drop.count", {16'd0, instr_count}, 32'd1);
        step(1); check_state("drop.idle", X_NONE, 16'h0000, 16'h0000, 5'b00000);
        step(1); check_state("drop.idle2", X_NONE, 16'h0000, 16'h0000, 5'b00000);

        // Counter wrap
        force dut.instr_count_r = 16'hFFFF;
        #1;
        release dut.instr_count_r;
        check("wrap.preload", {16'd0, instr_count}, 32'h0000_FFFF);
        run = 1'b1;
        step(6); check("wrap.count", {16'd0, instr_count}, 32'd0);
        check_state("wrap.t5", X_T5, 16'h0000, 16'h0002, 5'b00000);
        run = 1'b0;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  in  1  system clock; all state changes occur on the rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 run  in  1  level request to keep fetching and executing instructions.
REQ-004 IR_Data  in  32  instruction register contents from the datapath.
REQ-005 PC_select, Z_HI_select, Z_LO_select, MDR_select  out  1 each  bus encoder selects.
REQ-006 PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, read  out  1 each  register enables and the memory-read mux select.
REQ-007 reg_select_out  out  16  one-hot general-register bus select (R0..R15).
REQ-008 reg_enable  out  16  one-hot general-register write enable.
REQ-009 alu_instruction  out  5  ALU opcode.
REQ-010 done  out  1  one-cycle pulse when an instruction completes write-back.
REQ-011 illegal_op  out  1  one-cycle pulse when the opcode is unsupported.
REQ-012 halted  out  1  high while in HALT.
REQ-013 instr_count  out  16  count of completed instructions.

Function
REQ-014 States SHALL be IDLE, T0, T1, T2, T3, T4, T5 and HALT, one clock per state, with Moore outputs decoded from the state register.
REQ-015 IDLE->T0 when run=1; T0->T1->T2->T3 unconditionally; T3->T4 for a supported opcode; T4->T5; T5->T0 if run=1, otherwise IDLE.
REQ-016 T0 SHALL assert PC_select, MAR_enable, PC_increment_enable and Z_enable.
REQ-017 T1 SHALL assert Z_LO_select, PC_enable, read and MDR_enable.
REQ-018 T2 SHALL assert MDR_select and IR_enable.
REQ-019 T3 SHALL assert Y_enable and reg_select_out bit Rb.
REQ-020 T4 SHALL assert Z_enable, reg_select_out bit Rc, and alu_instruction = opcode.
REQ-021 T5 SHALL assert Z_LO_select, reg_enable bit Ra and done, and SHALL increment instr_count.
REQ-022 IR fields: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
REQ-023 Supported opcodes are 5'b00000 through 5'b01100, i.e. the register-register ALU operations.
REQ-024 Opcode 5'b11111 in T3 SHALL go to HALT with no Y_enable, and HALT SHALL hold until reset with halted=1.
REQ-025 Any other opcode in T3 SHALL pulse illegal_op, suppress Y_enable and reg_select_out, perform no write-back and no count, and go to T0 if run=1, else IDLE.
REQ-026 Every output not listed for a state SHALL be 0, and alu_instruction SHALL be 0 outside T4.
REQ-027 instr_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 Deasserting run mid-instruction SHALL let the instruction finish through T5, then enter IDLE.
REQ-029 Reg_enable SHALL never assert without a same-instruction pass through T4.

Reset
REQ-030 reset=1 SHALL force IDLE on the next edge from any state, including mid-instruction and HALT.
REQ-031 After reset all outputs SHALL be 0 and instr_count SHALL be 0.
REQ-032 Reset SHALL take priority over run.

Structure
REQ-033 The shared package SHALL hold the state enumeration, the opcode constants (ALU ops, HALT) and the IR field bit positions.
REQ-034 A sub-module reg_select_decoder SHALL implement the 4-to-16 one-hot decode and be instantiated for select and enable.
REQ-035 The block SHALL contain no datapath storage other than the state register and instr_count.

Verification
REQ-036 Reset, then run=1 with IR_Data=32'h509A8000 -> T3 reg_select_out=16'h0008; T4 reg_select_out=16'h0020 and alu_instruction=5'b01010; T5 reg_enable=16'h0002, done=1, instr_count=1.
REQ-037 run held high for 3 instructions -> T5->T0 with no IDLE gap, and instr_count=3 after 18 cycles.
REQ-038 IR_Data opcode 5'b10101 -> illegal_op pulses in T3, no reg_enable or done, next state T0.
REQ-039 IR_Data=32'hF8000000 -> HALT, halted=1 for 10 cycles despite run=1; reset -> IDLE, halted=0.
REQ-040 reset asserted during T4 -> next cycle IDLE with all outputs 0 and instr_count=0; run deasserted in T2 -> completes T5, then IDLE.
REQ-041 Preload instr_count to 16'hFFFF via 65535 instructions (or force) -> the next completion gives 16'h0000.
